// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response channel shared by the instruction, data and master sides of the arbiter.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wen, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wen, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// 2:1 inst/data arbiter onto one SRAM-like master with an in-order owner FIFO for response routing.
// Optional SRAM_ARB_RR_EN selects round-robin; otherwise data has fixed priority over instruction.
module sram_like_arbiter #(
  parameter int OUTST_DEPTH = 4,
  parameter int CNT_W       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_like_arbiter_if.slave   i_port,
  sram_like_arbiter_if.slave   d_port,
  sram_like_arbiter_if.master  m_port,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err
);
  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t                 state, state_n;
  logic                   gnt_i, gnt_d, hs, pop, full, empty, prio_d, head;
  logic [OUTST_DEPTH-1:0] owner_q;
  logic [PTR_W-1:0]       wptr, rptr;
  logic [CNT_W-1:0]       count;
  logic                   unused_i_wen;

  assign unused_i_wen = ^i_port.wen;

  assign full  = (count == CNT_W'(OUTST_DEPTH));
  assign empty = (count == '0);
  assign head  = owner_q[rptr];

`ifdef SRAM_ARB_RR_EN
  logic rr_d;
  // Priority goes to whichever port lost the last handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rr_d <= 1'b1;
    else if (hs) rr_d <= gnt_i;
  end
  assign prio_d = rr_d;
`else
  assign prio_d = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    state_n = state;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!full) begin
            if (d_port.req && (!i_port.req || prio_d)) gnt_d = 1'b1;
            else if (i_port.req)                        gnt_i = 1'b1;
          end
        end
        LOCK_I:  gnt_i = i_port.req;
        LOCK_D:  gnt_d = d_port.req;
        default: ;
      endcase
    end
    hs = (gnt_i | gnt_d) & m_port.addr_ok;
    // A grant without addr_ok is held; a dropped request or a handshake frees the channel.
    if (hs || !(gnt_i || gnt_d)) state_n = IDLE;
    else if (gnt_i)              state_n = LOCK_I;
    else                         state_n = LOCK_D;
  end

  always_comb begin
    m_port.req   = gnt_i | gnt_d;
    m_port.wr    = 1'b0;
    m_port.size  = 2'b00;
    m_port.wen   = 4'b0000;
    m_port.addr  = 32'h0;
    m_port.wdata = 32'h0;
    if (gnt_d) begin
      m_port.wr    = d_port.wr;
      m_port.size  = d_port.size;
      m_port.wen   = d_port.wen;
      m_port.addr  = d_port.addr;
      m_port.wdata = d_port.wdata;
    end else if (gnt_i) begin
      m_port.wr    = i_port.wr;
      m_port.size  = i_port.size;
      m_port.addr  = i_port.addr;
      m_port.wdata = i_port.wdata;
    end
  end

  assign i_port.addr_ok = hs & gnt_i;
  assign d_port.addr_ok = hs & gnt_d;

  assign pop            = m_port.data_ok & ~empty & ~rst;
  assign i_port.data_ok = pop & ~head;
  assign d_port.data_ok = pop & head;
  assign i_port.rdata   = m_port.rdata;
  assign d_port.rdata   = m_port.rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      if (hs) begin
        owner_q[wptr] <= gnt_d;
        wptr          <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({hs, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (m_port.data_ok && empty) err <= 1'b1;
    end
  end

  assign outstanding = count;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench: reset, vector table, round-robin/spurious sequences and a randomized model run.
module tb_sram_like_arbiter;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] outstanding;
  logic       err;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if i_bus ();
  sram_like_arbiter_if d_bus ();
  sram_like_arbiter_if m_bus ();

  sram_like_arbiter #(.OUTST_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .i_port(i_bus), .d_port(d_bus), .m_port(m_bus),
    .outstanding(outstanding), .err(err));

  typedef struct {
    bit ir, dr, aok, dok;
    int g;                 // 0 none, 1 inst, 2 data
    bit idk, ddk;
    int outst;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit ir, bit dr, bit aok, bit dok, int g, bit idk, bit ddk, int outst);
    vec_t r;
    r.ir = ir; r.dr = dr; r.aok = aok; r.dok = dok;
    r.g = g; r.idk = idk; r.ddk = ddk; r.outst = outst;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic drive(bit ir, bit dr, bit aok, bit dok);
    i_bus.req = ir;  d_bus.req = dr;
    m_bus.addr_ok = aok; m_bus.data_ok = dok;
    i_bus.addr = $urandom; i_bus.wdata = $urandom; i_bus.wr = 1'($urandom_range(0, 1));
    i_bus.size = 2'($urandom_range(0, 3)); i_bus.wen = 4'($urandom_range(0, 15));
    d_bus.addr = $urandom; d_bus.wdata = $urandom; d_bus.wr = 1'($urandom_range(0, 1));
    d_bus.size = 2'($urandom_range(0, 3)); d_bus.wen = 4'($urandom_range(0, 15));
    m_bus.rdata = $urandom;
  endtask

  task automatic chk_bus(string nm, int g, bit aok, bit idk, bit ddk, int outst, bit e);
    chk({nm, ".m_req"},   32'(m_bus.req), 32'(g != 0));
    chk({nm, ".m_addr"},  m_bus.addr,  g == 1 ? i_bus.addr  : g == 2 ? d_bus.addr  : 32'h0);
    chk({nm, ".m_wdata"}, m_bus.wdata, g == 1 ? i_bus.wdata : g == 2 ? d_bus.wdata : 32'h0);
    chk({nm, ".m_wen"},   32'(m_bus.wen), g == 2 ? 32'(d_bus.wen) : 32'h0);
    chk({nm, ".m_wr"},    32'(m_bus.wr), g == 1 ? 32'(i_bus.wr) : g == 2 ? 32'(d_bus.wr) : 32'h0);
    chk({nm, ".m_size"},  32'(m_bus.size), g == 1 ? 32'(i_bus.size) : g == 2 ? 32'(d_bus.size) : 32'h0);
    chk({nm, ".i_addr_ok"}, 32'(i_bus.addr_ok), 32'(g == 1 && aok));
    chk({nm, ".d_addr_ok"}, 32'(d_bus.addr_ok), 32'(g == 2 && aok));
    chk({nm, ".i_data_ok"}, 32'(i_bus.data_ok), 32'(idk));
    chk({nm, ".d_data_ok"}, 32'(d_bus.data_ok), 32'(ddk));
    chk({nm, ".outstanding"}, 32'(outstanding), 32'(outst));
    chk({nm, ".err"}, 32'(err), 32'(e));
    chk({nm, ".i_rdata"}, i_bus.rdata, m_bus.rdata);
    chk({nm, ".d_rdata"}, d_bus.rdata, m_bus.rdata);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int rr_g[4];
  int q[$];
  int hold, pref, g, psz;
  bit merr, ir, dr, aok, dok, pop;

  initial begin
    // Reset with every input active: outputs must stay quiet.
    rst = 1'b1;
    drive(1, 1, 1, 1);
    #2 chk_bus("reset", 0, 1, 0, 0, 0, 0);
    tick; tick;
    drive(1, 1, 1, 1);
    #3 chk_bus("reset_hold", 0, 1, 0, 0, 0, 0);
    tick;
    rst = 1'b0;

    // Post-reset grant, lock drop, lock, ordering, full, simultaneous push/pop.
    tbl.push_back(v(1,1,0,0, 2,0,0,0));
    tbl.push_back(v(1,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0, 2,0,0,0));
    tbl.push_back(v(1,1,0,0, 2,0,0,0));
    tbl.push_back(v(1,1,1,0, 2,0,0,0));
    tbl.push_back(v(1,0,1,0, 1,0,0,1));
    tbl.push_back(v(0,0,0,1, 0,0,1,2));
    tbl.push_back(v(0,0,0,1, 0,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,1,0, 1,0,0,0));
    tbl.push_back(v(0,1,1,0, 2,0,0,1));
    tbl.push_back(v(1,0,1,0, 1,0,0,2));
    tbl.push_back(v(0,0,0,1, 0,1,0,3));
    tbl.push_back(v(0,0,0,1, 0,0,1,2));
    tbl.push_back(v(0,0,0,1, 0,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1,0,1,0, 1,0,0,k));
    tbl.push_back(v(1,1,1,0, 0,0,0,4));
    tbl.push_back(v(1,1,1,1, 0,1,0,4));
    tbl.push_back(v(1,0,1,0, 1,0,0,3));
    for (int k = 4; k > 0; k--) tbl.push_back(v(0,0,0,1, 0,1,0,k));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0, 2,0,0,0));
    tbl.push_back(v(1,0,1,1, 1,0,1,1));
    tbl.push_back(v(0,0,0,1, 0,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].ir, tbl[k].dr, tbl[k].aok, tbl[k].dok);
      #3 chk_bus($sformatf("vec%0d", k), tbl[k].g, tbl[k].aok, tbl[k].idk, tbl[k].ddk, tbl[k].outst, 0);
      tick;
    end

    // Both requesting with addr_ok every cycle until full, then drain in order.
`ifdef SRAM_ARB_RR_EN
    rr_g = '{2, 1, 2, 1};
`else
    rr_g = '{2, 2, 2, 2};
`endif
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 0);
      #3 chk_bus($sformatf("rr%0d", k), rr_g[k], 1, 0, 0, k, 0);
      tick;
    end
    drive(1, 1, 1, 0);
    #3 chk_bus("rr_full", 0, 1, 0, 0, 4, 0);
    tick;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1);
      #3 chk_bus($sformatf("rr_drain%0d", k), 0, 0, rr_g[k] == 1, rr_g[k] == 2, 4 - k, 0);
      tick;
    end

    // Spurious response with an empty FIFO sets the sticky error.
    drive(0, 0, 0, 1);
    #3 chk_bus("spur", 0, 0, 0, 0, 0, 0);
    tick;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0);
      #3 chk_bus($sformatf("spur_sticky%0d", k), 0, 0, 0, 0, 0, 1);
      tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(0, 0, 0, 0);
    #3 chk_bus("spur_cleared", 0, 0, 0, 0, 0, 0);
    tick;

    // Randomized run against a transaction-level model of the arbitration rules.
    hold = 0; pref = 2; merr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ir  = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      aok = ($urandom_range(0, 2) != 0);
      dok = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
      drive(ir, dr, aok, dok);
      if (hold != 0)                g = ((hold == 1 && ir) || (hold == 2 && dr)) ? hold : 0;
      else if (q.size() == DEPTH)   g = 0;
      else if (ir && dr)            g = pref;
      else                          g = dr ? 2 : (ir ? 1 : 0);
      psz = q.size();
      pop = dok && psz > 0;
      #3 chk_bus($sformatf("rnd%0d", c), g, aok, pop && q[0] == 1, pop && q[0] == 2, psz, merr);
      tick;
      if (pop) void'(q.pop_front());
      if (dok && psz == 0) merr = 1'b1;
      if (g != 0 && aok) begin
        q.push_back(g);
        hold = 0;
`ifdef SRAM_ARB_RR_EN
        pref = (g == 1) ? 2 : 1;
`endif
      end else begin
        hold = g;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
